// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and forwarding-select constants for hazard_ctrl.
package hazard_pkg;
  typedef enum logic [1:0] {INIT, RUN, LDSTALL, MEMWAIT} state_e;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: selects the youngest in-flight producer of one EX source operand.
// Ports: src_i (EX source index), mem_rd_i/mem_regwrite_i and wb_rd_i/wb_regwrite_i
// (downstream writers), sel_o (FWD_RF / FWD_MEM / FWD_WB).
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REGINDEX = 5
) (
  input  logic [REGINDEX-1:0] src_i,
  input  logic [REGINDEX-1:0] mem_rd_i,
  input  logic                mem_regwrite_i,
  input  logic [REGINDEX-1:0] wb_rd_i,
  input  logic                wb_regwrite_i,
  output logic [1:0]          sel_o
);
  logic mem_hit, wb_hit;
  assign mem_hit = mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == src_i;
  assign wb_hit  = wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == src_i;
  assign sel_o   = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward controller for a 5-stage pipeline.
// Inputs: clk, rst (async active-low), ID sources, EX/MEM/WB destinations and
// write flags, ex_branch_taken, dmem_req/dmem_ready handshake.
// Outputs: pipeline-register enables/flushes, fwd_a/fwd_b operand selects,
// stall_cnt (saturating count of cycles with pc_en=0).
// Build option HAZARD_CTRL_FORWARD_EN: enables EX forwarding so only load-use
// stalls remain; without it every RAW on EX/MEM producers stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGINDEX = 5,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REGINDEX-1:0] id_rs1,
  input  logic [REGINDEX-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REGINDEX-1:0] ex_rs1,
  input  logic [REGINDEX-1:0] ex_rs2,
  input  logic [REGINDEX-1:0] ex_rd,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic [REGINDEX-1:0] mem_rd,
  input  logic                mem_regwrite,
  input  logic [REGINDEX-1:0] wb_rd,
  input  logic                wb_regwrite,
  input  logic                ex_branch_taken,
  input  logic                dmem_req,
  input  logic                dmem_ready,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_en,
  output logic                idex_flush,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNTW-1:0]     stall_cnt
);
`ifdef HAZARD_CTRL_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic mem_wait, load_use, raw, stall_req;
  logic [1:0] sel_a, sel_b;
  fwd_unit #(.REGINDEX(REGINDEX)) u_fwd_a (
    .src_i(ex_rs1), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .sel_o(sel_a)
  );
  fwd_unit #(.REGINDEX(REGINDEX)) u_fwd_b (
    .src_i(ex_rs2), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .sel_o(sel_b)
  );
  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = ex_memread && ex_regwrite && ex_rd != '0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  // Without forwarding, any used source still in flight in EX or MEM must wait;
  // WB needs no stall because the register file writes before it is read.
  assign raw = (id_use_rs1 && ((ex_regwrite && ex_rd != '0 && id_rs1 == ex_rd) ||
                               (mem_regwrite && mem_rd != '0 && id_rs1 == mem_rd))) ||
               (id_use_rs2 && ((ex_regwrite && ex_rd != '0 && id_rs2 == ex_rd) ||
                               (mem_regwrite && mem_rd != '0 && id_rs2 == mem_rd)));
  // With forwarding a load-use needs exactly one bubble, so LDSTALL never re-stalls.
  assign stall_req = FWD_EN ? (load_use && state_q == RUN) : raw;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:         state_d = RUN;
      RUN, LDSTALL: state_d = mem_wait ? MEMWAIT : ex_branch_taken ? RUN : stall_req ? LDSTALL : RUN;
      MEMWAIT:      state_d = dmem_ready ? RUN : MEMWAIT;
    endcase
  end
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    if (rst) begin
      unique case (state_q)
        INIT: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          {ifid_flush, idex_flush} = 2'b11;
        end
        MEMWAIT: {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = {5{dmem_ready}};
        default: begin
          pc_en      = !mem_wait && (ex_branch_taken || !stall_req);
          ifid_en    = pc_en;
          idex_en    = !mem_wait;
          exmem_en   = !mem_wait;
          memwb_en   = !mem_wait;
          ifid_flush = !mem_wait && ex_branch_taken;
          idex_flush = !mem_wait && (ex_branch_taken || stall_req);
        end
      endcase
    end
  end
  assign fwd_a     = (rst && FWD_EN) ? sel_a : FWD_RF;
  assign fwd_b     = (rst && FWD_EN) ? sel_b : FWD_RF;
  assign cnt_d     = (!pc_en && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (table, directed sequences, random vs model).
module tb_hazard_ctrl;
`ifdef HAZARD_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNTMAX = 65535;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic ex_branch_taken, dmem_req, dmem_ready;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  int total = 0, bad = 0;
  int mode = 0;
  int mcnt = 0;
  int n_mode;
  logic [6:0] e_ctl;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic bit in_flight(input logic [4:0] r);
    return (ex_regwrite && ex_rd != 0 && r == ex_rd) || (mem_regwrite && mem_rd != 0 && r == mem_rd);
  endfunction
  function automatic logic [1:0] pick(input logic [4:0] src);
    if (!FWD || !rst) return 2'b00;
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction
  // e_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  task automatic model();
    bit lu, raw, haz;
    lu = ex_memread && ex_regwrite && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    raw = (id_use_rs1 && in_flight(id_rs1)) || (id_use_rs2 && in_flight(id_rs2));
    haz = FWD ? lu : raw;
    n_mode = mode;
    if (!rst) begin e_ctl = 7'b0; n_mode = 0; end
    else if (mode == 0) begin e_ctl = 7'b1111111; n_mode = 1; end
    else if (mode == 3) begin e_ctl = dmem_ready ? 7'b1101011 : 7'b0; n_mode = dmem_ready ? 1 : 3; end
    else if (dmem_req && !dmem_ready) begin e_ctl = 7'b0; n_mode = 3; end
    else if (ex_branch_taken) begin e_ctl = 7'b1111111; n_mode = 1; end
    else if (haz && (mode == 1 || !FWD)) begin e_ctl = 7'b0001111; n_mode = 2; end
    else begin e_ctl = 7'b1101011; n_mode = 1; end
  endtask
  task automatic settle(); @(negedge clk); endtask
  task automatic adv();
    model();
    chk("model", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, fwd_a, fwd_b, stall_cnt},
        {e_ctl, pick(ex_rs1), pick(ex_rs2), mcnt[15:0]});
    @(posedge clk);
    model();
    if (!rst) begin mode = 0; mcnt = 0; end
    else begin
      if (!e_ctl[6] && mcnt < CNTMAX) mcnt++;
      mode = n_mode;
    end
    #1;
  endtask
  task automatic cycle(); settle(); adv(); endtask
  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite} = '0;
    {ex_branch_taken, dmem_req, dmem_ready} = '0;
  endtask
  task automatic set_reset();
    rst = 1'b0;
    mode = 0;
    mcnt = 0;
  endtask
  typedef struct {
    logic [4:0] rs1, rs2, mrd, wrd;
    logic mwe, wwe;
    logic [1:0] ea, eb;
  } fvec_t;
  fvec_t tbl[8];
  initial begin
    int c0;
    tbl[0] = '{7, 7, 7, 7, 1, 1, 2'b01, 2'b01};
    tbl[1] = '{7, 7, 0, 0, 1, 1, 2'b00, 2'b00};
    tbl[2] = '{7, 3, 7, 7, 0, 1, 2'b10, 2'b00};
    tbl[3] = '{7, 3, 3, 7, 1, 1, 2'b10, 2'b01};
    tbl[4] = '{4, 5, 4, 5, 1, 1, 2'b01, 2'b10};
    tbl[5] = '{9, 9, 9, 9, 0, 0, 2'b00, 2'b00};
    tbl[6] = '{1, 2, 2, 1, 1, 1, 2'b10, 2'b01};
    tbl[7] = '{31, 31, 31, 0, 1, 0, 2'b01, 2'b01};
    clr();
    #2 set_reset();
    settle();
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_ctl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, fwd_a, fwd_b}, 0);
    adv();
    rst = 1'b1;
    settle();
    chk("init_flush", {ifid_flush, idex_flush, pc_en}, 3'b111);
    adv();
    for (int i = 0; i < 8; i++) begin
      clr();
      ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2; mem_rd = tbl[i].mrd; wb_rd = tbl[i].wrd;
      mem_regwrite = tbl[i].mwe; wb_regwrite = tbl[i].wwe;
      settle();
      chk("fwd_tbl", {fwd_a, fwd_b}, FWD ? {tbl[i].ea, tbl[i].eb} : 4'b0);
      adv();
    end
    clr();
    c0 = mcnt;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    settle();
    chk("lu_stall", {pc_en, ifid_en, idex_flush}, 3'b001);
    adv();
    chk("lu_cnt", stall_cnt, c0 + 1);
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_rd = 5; mem_regwrite = 1;
    settle();
    chk("lu_after", pc_en, FWD ? 1 : 0);
    adv();
    mem_rd = 0; mem_regwrite = 0;
    settle();
    chk("lu_clear", pc_en, 1);
    adv();
    c0 = mcnt;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; ex_branch_taken = 1;
    settle();
    chk("br_lu", {pc_en, ifid_flush, idex_flush}, 3'b111);
    adv();
    chk("br_cnt", stall_cnt, c0);
    clr();
    cycle();
    c0 = mcnt;
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_hold", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
      adv();
    end
    dmem_ready = 1;
    settle();
    chk("mw_exit", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    adv();
    chk("mw_cnt", stall_cnt, c0 + 3);
    dmem_ready = 0;
    cycle();
    cycle();
    clr();
    set_reset();
    #1;
    chk("rst_async", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, stall_cnt}, 0);
    settle();
    adv();
    rst = 1'b1;
    settle();
    chk("rst_init", {ifid_flush, idex_flush}, 2'b11);
    adv();
    dmem_req = 1;
    for (int i = 0; i < CNTMAX + 5; i++) cycle();
    chk("sat", stall_cnt, CNTMAX);
    cycle();
    chk("sat_hold", stall_cnt, CNTMAX);
    clr();
    dmem_ready = 1;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite} = 6'($urandom);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ready = 1'($urandom);
      if ($urandom_range(0, 99) == 0) set_reset();
      else rst = 1'b1;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
